// File: rtl/parity_serial_rx_pkg.sv
// Shared definitions for the XOR-parity serial link: FSM encodings and default frame geometry.
package parity_serial_rx_pkg;

    localparam int unsigned DEFAULT_DATA_BITS  = 8;
    localparam int unsigned DEFAULT_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } rx_state_e;

endpackage

// File: rtl/parity_serial_rx_accum.sv
// Clear/enable running-XOR parity accumulator, shared between the link's receiver and transmitter.
module parity_accum (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic d,
    output logic acc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= 1'b0;
        end else if (clr) begin
            acc <= 1'b0;
        end else if (en) begin
            acc <= acc ^ d;
        end
    end

endmodule

// File: rtl/parity_serial_rx.sv
// XOR-parity serial receiver: oversampled start/data/parity/stop framing into a valid/ready word
// with parity, framing and overrun reporting.
module parity_serial_rx
    import parity_serial_rx_pkg::*;
#(
    parameter int unsigned DATA_BITS  = DEFAULT_DATA_BITS,
    parameter int unsigned OVERSAMPLE = DEFAULT_OVERSAMPLE,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sample_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_parity_err,
    output logic                 out_frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W  = $clog2(DATA_BITS + 1);

    rx_state_e state, state_next;

    logic [1:0]           sync_q;
    logic                 rx_s;
    logic [TICK_W-1:0]    tick_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 acc;
    logic                 perr_q;
    logic                 ferr_q;
    logic                 done_q;

    logic tick_half_c, tick_full_c, bit_last_c;
    logic tick_clr_c, tick_inc_c, bit_clr_c, bit_inc_c;
    logic shift_en_c, acc_clr_c, par_sample_c, stop_sample_c;

    // Two-flop synchroniser, idles high so reset does not look like a start bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx};
        end
    end

    assign rx_s = sync_q[1];

    assign tick_half_c = (tick_cnt == TICK_W'(OVERSAMPLE / 2 - 1));
    assign tick_full_c = (tick_cnt == TICK_W'(OVERSAMPLE - 1));
    assign bit_last_c  = (bit_cnt == BIT_W'(DATA_BITS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (sample_tick) begin
            case (state)
                ST_IDLE:      if (!rx_s) state_next = ST_START;
                ST_START:     if (tick_half_c) state_next = rx_s ? ST_IDLE : ST_DATA;
                ST_DATA:      if (tick_full_c && bit_last_c) state_next = ST_PARITY;
                ST_PARITY:    if (tick_full_c) state_next = ST_STOP;
                ST_STOP:      if (tick_full_c) state_next = rx_s ? ST_IDLE : ST_WAIT_IDLE;
                ST_WAIT_IDLE: if (rx_s) state_next = ST_IDLE;
                default:      state_next = ST_IDLE;
            endcase
        end
    end

    // Datapath strobes; every sample point also restarts the tick counter
    always_comb begin
        tick_clr_c    = 1'b0;
        tick_inc_c    = 1'b0;
        bit_clr_c     = 1'b0;
        bit_inc_c     = 1'b0;
        shift_en_c    = 1'b0;
        acc_clr_c     = 1'b0;
        par_sample_c  = 1'b0;
        stop_sample_c = 1'b0;
        if (sample_tick) begin
            case (state)
                ST_IDLE: begin
                    if (!rx_s) tick_clr_c = 1'b1;
                end
                ST_START: begin
                    if (tick_half_c) begin
                        tick_clr_c = 1'b1;
                        bit_clr_c  = 1'b1;
                        acc_clr_c  = 1'b1;
                    end else begin
                        tick_inc_c = 1'b1;
                    end
                end
                ST_DATA: begin
                    if (tick_full_c) begin
                        tick_clr_c = 1'b1;
                        shift_en_c = 1'b1;
                        bit_inc_c  = 1'b1;
                    end else begin
                        tick_inc_c = 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (tick_full_c) begin
                        tick_clr_c   = 1'b1;
                        par_sample_c = 1'b1;
                    end else begin
                        tick_inc_c = 1'b1;
                    end
                end
                ST_STOP: begin
                    if (tick_full_c) begin
                        tick_clr_c    = 1'b1;
                        stop_sample_c = 1'b1;
                    end else begin
                        tick_inc_c = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            if (tick_clr_c) begin
                tick_cnt <= '0;
            end else if (tick_inc_c) begin
                tick_cnt <= tick_cnt + TICK_W'(1);
            end
            if (bit_clr_c) begin
                bit_cnt <= '0;
            end else if (bit_inc_c) begin
                bit_cnt <= bit_cnt + BIT_W'(1);
            end
            if (shift_en_c) begin
                shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            end
            if (par_sample_c) begin
                perr_q <= acc ^ rx_s ^ PARITY_ODD;
            end
            if (stop_sample_c) begin
                ferr_q <= ~rx_s;
            end
            done_q <= stop_sample_c;
        end
    end

    parity_accum u_accum (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (acc_clr_c),
        .en    (shift_en_c),
        .d     (rx_s),
        .acc   (acc)
    );

    // Output word register: a completed frame loads unless an unaccepted word is still held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data       <= '0;
            out_valid      <= 1'b0;
            out_parity_err <= 1'b0;
            out_frame_err  <= 1'b0;
            overrun        <= 1'b0;
            busy           <= 1'b0;
        end else begin
            busy    <= (state_next != ST_IDLE);
            overrun <= 1'b0;
            if (done_q && (!out_valid || out_ready)) begin
                out_data       <= shreg;
                out_parity_err <= perr_q;
                out_frame_err  <= ferr_q;
                out_valid      <= 1'b1;
            end else begin
                if (done_q) begin
                    overrun <= 1'b1;
                end
                if (out_valid && out_ready) begin
                    out_valid      <= 1'b0;
                    out_parity_err <= 1'b0;
                    out_frame_err  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_parity_serial_rx.sv
// Directed bench for parity_serial_rx: frame-level model queue plus per-cycle output compare.
module tb_parity_serial_rx;

    localparam int unsigned BIT_CLK    = 16;
    localparam bit          PARITY_ODD = 1'b0;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sample_tick;
    logic       rx;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_parity_err;
    logic       out_frame_err;
    logic       overrun;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int words = 0;
    int last_len = 0;
    int run = 0;
    int ovr_seen = 0;
    int exp_ovr = 0;
    logic prev_valid = 1'b0;
    logic hs_prev = 1'b0;
    logic prev_ovr = 1'b0;
    exp_t cur_exp;
    logic [7:0] cap_data;
    logic cap_perr, cap_ferr;
    exp_t exp_q[$];

    parity_serial_rx dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sample_tick    (sample_tick),
        .rx             (rx),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_parity_err (out_parity_err),
        .out_frame_err  (out_frame_err),
        .overrun        (overrun),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame model: queue the word the receiver must present, or count the drop it must report
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp, input bit drop);
        exp_t e;
        logic [10:0] bits;
        if (drop) begin
            exp_ovr++;
        end else begin
            e.data = d;
            e.perr = (^d) ^ par ^ PARITY_ODD;
            e.ferr = ~stp;
            exp_q.push_back(e);
        end
        bits = {stp, par, d, 1'b0};
        for (int k = 0; k < 11; k++) begin
            rx = bits[k];
            repeat (BIT_CLK) @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_words(input int target, input int budget);
        int n;
        n = 0;
        while (words < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("word_arrival", 32'(words >= target), 32'd1);
    endtask

    // Per-cycle compare of presented words, stability, idle flags and overrun pulses
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
            hs_prev    = 1'b0;
            prev_ovr   = 1'b0;
            run        = 0;
        end else begin
            if (out_valid) begin
                if (!prev_valid || hs_prev) begin
                    if (prev_valid) last_len = run;
                    if (exp_q.size() == 0) begin
                        check("unexpected_word", 32'(out_valid), 32'd0);
                        cur_exp = '0;
                    end else begin
                        cur_exp = exp_q.pop_front();
                    end
                    cap_data = out_data;
                    cap_perr = out_parity_err;
                    cap_ferr = out_frame_err;
                    run = 1;
                    words++;
                end else begin
                    run++;
                end
                check("word_data", 32'(out_data), 32'(cur_exp.data));
                check("word_perr", 32'(out_parity_err), 32'(cur_exp.perr));
                check("word_ferr", 32'(out_frame_err), 32'(cur_exp.ferr));
            end else begin
                check("idle_flags", 32'({out_parity_err, out_frame_err}), 32'd0);
                if (prev_valid) last_len = run;
                run = 0;
            end
            if (overrun) begin
                ovr_seen++;
                check("overrun_while_valid", 32'(out_valid), 32'd1);
                check("overrun_width", 32'(prev_ovr), 32'd0);
            end
            prev_valid = out_valid;
            hs_prev    = out_valid && out_ready;
            prev_ovr   = overrun;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int w0;
        rst_n       = 1'b0;
        rx          = 1'b1;
        out_ready   = 1'b1;
        sample_tick = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_flags", 32'({out_parity_err, out_frame_err}), 32'd0);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;

        // Clean 0xA5, consumer always ready
        w0 = words;
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
        wait_words(w0 + 1, 40);
        repeat (2) @(posedge clk);
        #1;
        check("a5_data_lit", 32'(cap_data), 32'hA5);
        check("a5_flags_lit", 32'({cap_perr, cap_ferr}), 32'd0);
        check("a5_valid_len", 32'(last_len), 32'd1);
        check("a5_busy_after", 32'(busy), 32'd0);

        // Wrong parity bit
        w0 = words;
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
        wait_words(w0 + 1, 40);
        check("perr_data_lit", 32'(cap_data), 32'hA5);
        check("perr_flags_lit", 32'({cap_perr, cap_ferr}), 32'b10);

        // Stop bit low, line held low as a break
        w0 = words;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        repeat (40) @(posedge clk);
        #1;
        check("break_busy_held", 32'(busy), 32'd1);
        check("ferr_data_lit", 32'(cap_data), 32'h3C);
        check("ferr_flags_lit", 32'({cap_perr, cap_ferr}), 32'b01);
        rx = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("break_busy_release", 32'(busy), 32'd0);
        repeat (200) @(posedge clk);
        #1;
        check("break_no_retrigger", 32'(words), 32'(w0 + 1));

        // Short low glitch on idle line
        w0 = words;
        rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (1) @(posedge clk);
        #1;
        check("glitch_busy_seen", 32'(busy), 32'd1);
        repeat (7) @(posedge clk);
        #1;
        check("glitch_busy_clear", 32'(busy), 32'd0);
        repeat (50) @(posedge clk);
        #1;
        check("glitch_no_word", 32'(words), 32'(w0));

        // Consumer stalled: second frame is dropped
        w0 = words;
        out_ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b1, 1'b0);
        send_frame(8'h22, 1'b0, 1'b1, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        check("ovr_hold_valid", 32'(out_valid), 32'd1);
        check("ovr_hold_data_lit", 32'(out_data), 32'h11);
        check("ovr_words", 32'(words), 32'(w0 + 1));
        check("ovr_pulses", 32'(ovr_seen), 32'd1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("ovr_release_valid", 32'(out_valid), 32'd0);

        // Reset in the middle of the data bits
        rx = 1'b0;
        repeat (BIT_CLK) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (BIT_CLK) @(posedge clk);
        #1;
        rx = 1'b0;
        repeat (BIT_CLK) @(posedge clk);
        #1;
        check("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        rx = 1'b1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        w0 = words;
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
        wait_words(w0 + 1, 40);
        check("after_rst_data_lit", 32'(cap_data), 32'h5A);
        check("after_rst_flags_lit", 32'({cap_perr, cap_ferr}), 32'd0);

        repeat (20) @(posedge clk);
        #1;
        check("model_queue_drained", 32'(exp_q.size()), 32'd0);
        check("overrun_total", 32'(ovr_seen), 32'(exp_ovr));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/parity_serial_rx.md
Name: parity_serial_rx

Overview:
- Serial receiver for the team's XOR-parity link: accepts an asynchronous 1-bit line carrying start, DATA_BITS data (LSB first), parity and stop.
- Rebuilds the parallel word and checks parity with a running XOR.
- Flags parity, framing and overrun errors.
- Sits at the receive end of the serial path, opposite the parity-generating transmitter, and feeds parallel consumers through a valid/ready handshake.

Parameters:
- DATA_BITS, 8: data bits per frame, range 5..9.
- OVERSAMPLE, 16: sample_tick pulses per bit period; even, at least 4.
- PARITY_ODD, 0: 0 means even parity (XOR of data and parity bit = 0); 1 means odd parity (XOR = 1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- sample_tick  input  1  oversample enable, one-clk pulse; tying it to 1 is legal.
- rx  input  1  serial line, idles high, asynchronous to clk.
- out_data  output  DATA_BITS  received word.
- out_valid  output  1  out_data and the error flags are valid.
- out_ready  input  1  consumer accepts the word when out_valid & out_ready.
- out_parity_err  output  1  parity mismatch for the presented word.
- out_frame_err  output  1  stop bit sampled low for the presented word.
- overrun  output  1  one-clk pulse when a completed frame was dropped.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset: rst_n low asynchronously clears everything:
  - state goes to IDLE;
  - all counters are cleared;
  - the synchroniser flops are set to 1;
  - out_data=0, out_valid=0, out_parity_err=0, out_frame_err=0, overrun=0, busy=0.
- Reset mid-frame abandons the frame with no output and no error.
- Synchroniser: rx passes through 2 flops to give rx_s. All decisions use rx_s, which adds 2 clk of latency.
- Counters advance only on clk edges where sample_tick=1:
  - tick_cnt is log2(OVERSAMPLE) bits wide;
  - bit_cnt is log2(DATA_BITS+1) bits wide.
- IDLE: on a tick with rx_s=0, clear tick_cnt and go to START.
- START: count OVERSAMPLE/2 ticks (mid start bit) and sample rx_s.
  - rx_s=0: go to DATA; clear tick_cnt, bit_cnt and the parity accumulator.
  - rx_s=1: glitch; return to IDLE with no output.
- DATA: sample every OVERSAMPLE ticks, at mid-bit.
  - Each sample shifts in at the MSB end (LSB first on the line) and is XORed into the accumulator.
  - After DATA_BITS samples, go to PARITY.
- PARITY: after OVERSAMPLE ticks, sample. perr = acc ^ sample ^ PARITY_ODD. Go to STOP.
- STOP: after OVERSAMPLE ticks, sample. ferr = ~sample. This tick is the completion event.
  - Sample = 1: go to IDLE.
  - Sample = 0: go to WAIT_IDLE.
- WAIT_IDLE: stay until a tick with rx_s=1, then go to IDLE. This prevents a break condition from retriggering reception.
- Completion:
  - out_valid=0 at completion: on the next clk edge, load out_data, out_parity_err=perr, out_frame_err=ferr, and set out_valid=1. Latency is 1 clk from the stop-sample edge.
  - out_valid=1 and out_ready=0 at completion: the new frame is discarded, the outputs hold the old word, and overrun pulses for exactly 1 clk.
  - out_valid=1 and out_ready=1 on the completion edge: the handshake and the new load happen together. The new word loads, out_valid stays 1, and there is no overrun.
- Handshake:
  - out_valid stays 1 until out_valid & out_ready; it clears on that edge unless a new word loads on the same edge.
  - out_data and the error flags are stable while out_valid=1.
  - Error flags are cleared together with out_valid.
- sample_tick=0 freezes all counters and the FSM; only the synchroniser and the handshake keep operating.

Decomposition:
- Shared include file, one per link, holds:
  - the state encodings: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, WAIT_IDLE=5, as 3-bit localparams/`defines;
  - the default DATA_BITS/OVERSAMPLE values, also used by the transmitter.
- One natural sub-module: parity_accum, a clear/enable XOR accumulator reusable by the transmitter.

Test Plan (DATA_BITS=8, OVERSAMPLE=16, sample_tick tied 1, bit period = 16 clk, PARITY_ODD=0):
- Send 0xA5 (line: 0, 1,0,1,0,0,1,0,1, parity 0, stop 1) with out_ready=1 -> out_valid pulses 1 clk with out_data=0xA5, parity_err=0, frame_err=0; busy=0 after the stop bit.
- Send 0xA5 with parity bit 1 -> out_data=0xA5, out_parity_err=1, out_frame_err=0.
- Send 0x3C with stop bit 0, line held low 40 clk, then high -> out_frame_err=1; busy stays 1 until rx_s returns high, and no second frame starts.
- Drive a 4-clk low glitch on an idle line -> no out_valid; FSM back in IDLE within 2+8+1 clk; busy returns to 0.
- out_ready=0, send 0x11 then 0x22 back-to-back -> out_data holds 0x11, overrun pulses 1 clk at the end of the second frame; raising out_ready clears out_valid.
- Assert rst_n=0 mid DATA for 3 clk, then send 0x5A -> no output from the aborted frame; next out_data=0x5A with no errors.
